y86_seq_controller: RTL and testbench

Stage sequencer for the sequential Y86 core. It holds the architectural PC and steps one instruction at a time through fetch, decode, execute, memory, writeback and PC-update, one stage per state. It issues per-stage enables and write strobes, handles the data-memory wait handshake, and maintains Y86 status (AOK/HLT/ADR/INS). The PC-update stage computes pc_new combinationally; this block registers it.

---
 rtl/y86_seq_controller_if.sv | 54 +++++
 rtl/y86_seq_controller.sv | 242 ++++++++++++++++++++++++
 tb/tb_y86_seq_controller.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/y86_seq_controller_if.sv
// Bus between the Y86 sequential stage controller and the datapath.
// master: the controller side (drives PC, stage enables, strobes, status).
// slave:  the datapath / environment side.
// Optional macro CYCLE_CNT_EN adds the cycle_count signal.
interface y86_seq_controller_if #(
  parameter int CNT_W = 32
);
  logic              start;
  logic              step;
  logic [3:0]        icode;
  logic              instr_valid;
  logic              imem_error;
  logic              cond;
  logic              dmem_ready;
  logic              dmem_error;
  logic [63:0]       pc_new;

  logic [63:0]       pc;
  logic              fetch_en;
  logic              decode_en;
  logic              execute_en;
  logic              memory_en;
  logic              writeback_en;
  logic              pcupd_en;
  logic              cc_we;
  logic              reg_we;
  logic              dmem_req;
  logic [2:0]        stat;
  logic              busy;
  logic [CNT_W-1:0]  instr_count;
`ifdef CYCLE_CNT_EN
  logic [CNT_W-1:0]  cycle_count;
`endif

  modport master (
    input  start, step, icode, instr_valid, imem_error, cond,
           dmem_ready, dmem_error, pc_new,
    output pc, fetch_en, decode_en, execute_en, memory_en, writeback_en,
           pcupd_en, cc_we, reg_we, dmem_req, stat, busy, instr_count
`ifdef CYCLE_CNT_EN
    , output cycle_count
`endif
  );

  modport slave (
    output start, step, icode, instr_valid, imem_error, cond,
           dmem_ready, dmem_error, pc_new,
    input  pc, fetch_en, decode_en, execute_en, memory_en, writeback_en,
           pcupd_en, cc_we, reg_we, dmem_req, stat, busy, instr_count
`ifdef CYCLE_CNT_EN
    , input cycle_count
`endif
  );
endinterface

// File: rtl/y86_seq_controller.sv
// Stage sequencer for the sequential Y86 core. Walks each instruction
// through FETCH, DECODE, EXECUTE, (MEMORY), WRITEBACK and PCUPD, one stage
// per state, owns the architectural PC, the Y86 status code and the
// retired-instruction counter, and bounds data-memory waits with a timeout.
// Optional macro CYCLE_CNT_EN adds a busy-cycle counter (cycle_count).
module y86_seq_controller #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          MEM_TIMEOUT = 16,
  parameter int          CNT_W       = 32
) (
  input  logic                clock,
  input  logic                reset,
  y86_seq_controller_if.master bus
);

  // Timer must be able to hold MEM_TIMEOUT (it counts one past the last
  // MEMORY cycle on the exit edge before being cleared).
  localparam int               TMR_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALTED
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [3:0]        icode_q;
  logic [63:0]       pc_q;
  logic [2:0]        stat_q;
  logic [2:0]        stat_d;
  logic [CNT_W-1:0]  icnt_q;
  logic [TMR_W-1:0]  tmr_q;
  logic              retire;
  logic              mem_expired;

  logic              fetch_en;
  logic              decode_en;
  logic              execute_en;
  logic              memory_en;
  logic              writeback_en;
  logic              pcupd_en;
  logic              cc_we;
  logic              reg_we;
  logic              dmem_req;
  logic              busy;

  // Instructions that touch data memory: rmmovq, mrmovq, call, ret, pushq, popq.
  function automatic logic needs_memory(input logic [3:0] ic);
    return (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) ||
           (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
  endfunction

  // Register-file writers; cmovXX (icode 2) writes only when its condition holds.
  function automatic logic writes_reg(input logic [3:0] ic, input logic c);
    logic w;
    case (ic)
      4'h2:                      w = c;
      4'h3, 4'h5, 4'h6, 4'h8,
      4'h9, 4'hA, 4'hB:          w = 1'b1;
      default:                   w = 1'b0;
    endcase
    return w;
  endfunction

  // Only OPq updates the condition codes.
  function automatic logic sets_cc(input logic [3:0] ic);
    return ic == 4'h6;
  endfunction

  assign mem_expired = (tmr_q == TMR_LAST);

  // Next-state, next-status and retire decision.
  always_comb begin
    state_d = state;
    stat_d  = stat_q;
    retire  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        // An address fault outranks an illegal-instruction fault.
        if (bus.imem_error) begin
          state_d = S_HALTED;
          stat_d  = STAT_ADR;
        end else if (!bus.instr_valid) begin
          state_d = S_HALTED;
          stat_d  = STAT_INS;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d = needs_memory(icode_q) ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        // A ready arriving on the final allowed cycle still completes.
        if (bus.dmem_ready) begin
          if (bus.dmem_error) begin
            state_d = S_HALTED;
            stat_d  = STAT_ADR;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (mem_expired) begin
          state_d = S_HALTED;
          stat_d  = STAT_ADR;
        end
      end
      S_WRITEBACK: begin
        state_d = S_PCUPD;
      end
      S_PCUPD: begin
        // A halt instruction still retires: PC and count update before stopping.
        retire = 1'b1;
        if (icode_q == 4'h0) begin
          state_d = S_HALTED;
          stat_d  = STAT_HLT;
        end else if (bus.step) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Architectural PC, status and retired-instruction counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      stat_q <= STAT_AOK;
      icnt_q <= '0;
    end else begin
      stat_q <= stat_d;
      if (retire) begin
        pc_q   <= bus.pc_new;
        icnt_q <= icnt_q + 1'b1;
      end
    end
  end

  // Memory-wait timer: zero outside MEMORY, so every MEMORY visit starts at 0.
  always_ff @(posedge clock) begin
    if (reset)                 tmr_q <= '0;
    else if (state == S_MEMORY) tmr_q <= tmr_q + 1'b1;
    else                       tmr_q <= '0;
  end

  // Capture the instruction code while it is valid in FETCH.
  always_ff @(posedge clock) begin
    if (state == S_FETCH) icode_q <= bus.icode;
  end

  // Stage enables and strobes decoded from the registered state.
  always_comb begin
    fetch_en     = 1'b0;
    decode_en    = 1'b0;
    execute_en   = 1'b0;
    memory_en    = 1'b0;
    writeback_en = 1'b0;
    pcupd_en     = 1'b0;
    cc_we        = 1'b0;
    reg_we       = 1'b0;
    dmem_req     = 1'b0;
    busy         = 1'b1;
    case (state)
      S_IDLE:      busy = 1'b0;
      S_FETCH:     fetch_en = 1'b1;
      S_DECODE:    decode_en = 1'b1;
      S_EXECUTE: begin
        execute_en = 1'b1;
        cc_we      = sets_cc(icode_q);
      end
      S_MEMORY: begin
        memory_en = 1'b1;
        dmem_req  = 1'b1;
      end
      S_WRITEBACK: begin
        writeback_en = 1'b1;
        reg_we       = writes_reg(icode_q, bus.cond);
      end
      S_PCUPD:     pcupd_en = 1'b1;
      S_HALTED:    busy = 1'b0;
      default:     busy = 1'b0;
    endcase
  end

`ifdef CYCLE_CNT_EN
  logic [CNT_W-1:0] cyc_q;

  // Busy-cycle counter; frozen in IDLE and HALTED.
  always_ff @(posedge clock) begin
    if (reset)     cyc_q <= '0;
    else if (busy) cyc_q <= cyc_q + 1'b1;
  end

  assign bus.cycle_count = cyc_q;
`endif

  assign bus.pc           = pc_q;
  assign bus.stat         = stat_q;
  assign bus.instr_count  = icnt_q;
  assign bus.fetch_en     = fetch_en;
  assign bus.decode_en    = decode_en;
  assign bus.execute_en   = execute_en;
  assign bus.memory_en    = memory_en;
  assign bus.writeback_en = writeback_en;
  assign bus.pcupd_en     = pcupd_en;
  assign bus.cc_we        = cc_we;
  assign bus.reg_we       = reg_we;
  assign bus.dmem_req     = dmem_req;
  assign bus.busy         = busy;

endmodule

// File: tb/tb_y86_seq_controller.sv
// Randomized self-checking bench for y86_seq_controller. Each instruction is
// described as a transaction (icode, validity, faults, cond, memory latency)
// and its expected outcome (cycle count, strobe pulses, PC, status, count)
// is computed from the instruction-level rules.
module tb_y86_seq_controller;

  localparam logic [63:0] RESET_PC    = 64'h0000_0000_0000_1000;
  localparam int          MEM_TIMEOUT = 16;
  localparam int          CNT_W       = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  y86_seq_controller_if #(.CNT_W(CNT_W)) bus ();

  y86_seq_controller #(
    .RESET_PC   (RESET_PC),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_pc;
  int          exp_cnt;
  logic [2:0]  exp_stat;
`ifdef CYCLE_CNT_EN
  longint      exp_cyc;
`endif

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle_inputs();
    bus.start       = 1'b0;
    bus.step        = 1'b0;
    bus.icode       = 4'h1;
    bus.instr_valid = 1'b1;
    bus.imem_error  = 1'b0;
    bus.cond        = 1'b0;
    bus.dmem_ready  = 1'b0;
    bus.dmem_error  = 1'b0;
    bus.pc_new      = 64'h0;
  endtask

  task automatic check_arch(input string tag);
    check_val({tag, "_pc"},    bus.pc, exp_pc);
    check_val({tag, "_count"}, 64'(bus.instr_count), 64'(exp_cnt % (1 << CNT_W)));
    check_val({tag, "_stat"},  64'(bus.stat), 64'(exp_stat));
`ifdef CYCLE_CNT_EN
    check_val({tag, "_cycles"}, 64'(bus.cycle_count), 64'(exp_cyc % (1 << CNT_W)));
`endif
  endtask

  task automatic do_reset();
    int outs;
    drive_idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_pc   = RESET_PC;
    exp_cnt  = 0;
    exp_stat = 3'd1;
`ifdef CYCLE_CNT_EN
    exp_cyc  = 0;
`endif
    outs = int'(bus.fetch_en) + int'(bus.decode_en) + int'(bus.execute_en) +
           int'(bus.memory_en) + int'(bus.writeback_en) + int'(bus.pcupd_en) +
           int'(bus.cc_we) + int'(bus.reg_we) + int'(bus.dmem_req) + int'(bus.busy);
    check_val("reset_outputs", 64'(outs), 64'd0);
    check_arch("reset");
  endtask

  // Runs one instruction. Entry: at a negedge with the DUT in IDLE or FETCH.
  // mem_n = MEMORY cycle on which dmem_ready rises (0 = never, forcing timeout).
  task automatic exec_one(input logic [3:0] ic, input bit valid, input bit ierr,
                          input bit cnd, input logic [63:0] pnew, input bit stp,
                          input int mem_n, input bit merr);
    int cycles = 0, ncc = 0, nreg = 0, nreq = 0, mcyc = 0, bad_oh = 0, oh;
    bit retired = 1'b0;
    bit is_mem, writes;
    int exp_cycles, exp_mc, exp_ccn, exp_regn, exp_busy;
    bit exp_ret;

    if (!bus.busy) begin
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
    end
    bus.icode       = ic;
    bus.instr_valid = valid;
    bus.imem_error  = ierr;
    bus.cond        = cnd;
    bus.pc_new      = pnew;
    bus.step        = stp;

    for (int k = 0; k < 200; k++) begin
      cycles++;
      oh = int'(bus.fetch_en) + int'(bus.decode_en) + int'(bus.execute_en) +
           int'(bus.memory_en) + int'(bus.writeback_en) + int'(bus.pcupd_en);
      if (oh != 1) bad_oh++;
      ncc  += int'(bus.cc_we);
      nreg += int'(bus.reg_we);
      nreq += int'(bus.dmem_req);
      if (bus.memory_en) begin
        mcyc++;
        bus.dmem_ready = (mem_n != 0) && (mcyc == mem_n);
        bus.dmem_error = bus.dmem_ready ? merr : 1'($urandom_range(0, 1));
      end else begin
        bus.dmem_ready = 1'b0;
        bus.dmem_error = 1'b0;
      end
      if (bus.pcupd_en) begin
        retired = 1'b1;
        break;
      end
      @(negedge clock);
      if (!bus.busy) break;
    end
    bus.dmem_ready = 1'b0;
    bus.dmem_error = 1'b0;
    if (retired) @(negedge clock);

    // Instruction-level reference.
    is_mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    writes = (ic inside {4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) || (ic == 4'h2 && cnd);
    exp_ccn  = 0;
    exp_regn = 0;
    exp_mc   = 0;
    exp_ret  = 1'b0;
    if (ierr || !valid) begin
      exp_cycles = 1;
      exp_stat   = ierr ? 3'd3 : 3'd4;
    end else if (is_mem && (mem_n == 0 || merr)) begin
      exp_mc     = (mem_n == 0) ? MEM_TIMEOUT : mem_n;
      exp_cycles = 3 + exp_mc;
      exp_stat   = 3'd3;
    end else begin
      exp_mc     = is_mem ? mem_n : 0;
      exp_cycles = 5 + exp_mc;
      exp_ccn    = (ic == 4'h6) ? 1 : 0;
      exp_regn   = writes ? 1 : 0;
      exp_ret    = 1'b1;
      exp_pc     = pnew;
      exp_cnt    = exp_cnt + 1;
      exp_stat   = (ic == 4'h0) ? 3'd2 : 3'd1;
    end
`ifdef CYCLE_CNT_EN
    exp_cyc = exp_cyc + exp_cycles;
`endif
    exp_busy = (exp_stat == 3'd1 && !stp) ? 1 : 0;

    check_val("cycles",   64'(cycles), 64'(exp_cycles));
    check_val("onehot",   64'(bad_oh), 64'd0);
    check_val("cc_we",    64'(ncc),    64'(exp_ccn));
    check_val("reg_we",   64'(nreg),   64'(exp_regn));
    check_val("dmem_req", 64'(nreq),   64'(exp_mc));
    check_val("retired",  64'(retired), 64'(exp_ret));
    check_val("busy_after", 64'(bus.busy), 64'(exp_busy));
    check_arch("instr");
  endtask

  // After a halt: start must not restart execution, and state stays frozen.
  task automatic check_halted_frozen();
    bus.start = 1'b1;
    repeat (4) @(negedge clock);
    bus.start = 1'b0;
    check_val("halted_busy", 64'(bus.busy), 64'd0);
    check_arch("halted");
  endtask

  initial begin
    drive_idle_inputs();
    do_reset();

    // OPq, continuing into the next FETCH.
    exec_one(4'h6, 1, 0, 0, 64'h2, 0, 0, 0);
    // rmmovq with ready on the third MEMORY cycle, twice back to back.
    exec_one(4'h4, 1, 0, 0, 64'h20, 0, 3, 0);
    exec_one(4'h4, 1, 0, 0, 64'h2A, 0, 3, 0);
    // cmov with cond=0, then cond=1 in single-step mode.
    exec_one(4'h2, 1, 0, 0, 64'h2C, 0, 0, 0);
    exec_one(4'h2, 1, 0, 1, 64'h2E, 1, 0, 0);
    // ready exactly on the expiry cycle completes normally.
    exec_one(4'h5, 1, 0, 0, 64'h40, 1, MEM_TIMEOUT, 0);
    // Memory timeout -> ADR, PC unchanged, start ignored afterwards.
    exec_one(4'h4, 1, 0, 0, 64'hDEAD, 0, 0, 0);
    check_halted_frozen();
    do_reset();
    // Data memory error.
    exec_one(4'hA, 1, 0, 0, 64'hBEEF, 0, 2, 1);
    do_reset();
    // Illegal instruction.
    exec_one(4'h6, 0, 0, 0, 64'h77, 0, 0, 0);
    check_halted_frozen();
    do_reset();
    // Fetch address fault wins over illegal instruction.
    exec_one(4'h6, 0, 1, 0, 64'h77, 0, 0, 0);
    do_reset();
    // halt retires with the new PC, then freezes.
    exec_one(4'h0, 1, 0, 0, 64'h1234, 0, 0, 0);
    check_halted_frozen();
    do_reset();

    // Reset mid-EXECUTE.
    exec_one(4'h6, 1, 0, 0, 64'h50, 1, 0, 0);
    exec_one(4'h3, 1, 0, 0, 64'h5A, 1, 0, 0);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    bus.icode = 4'h6;
    for (int k = 0; k < 8 && !bus.execute_en; k++) @(negedge clock);
    check_val("reached_execute", 64'(bus.execute_en), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_pc   = RESET_PC;
    exp_cnt  = 0;
    exp_stat = 3'd1;
`ifdef CYCLE_CNT_EN
    exp_cyc  = 0;
`endif
    check_val("midreset_busy", 64'(bus.busy), 64'd0);
    check_arch("midreset");
    @(negedge clock);
    check_val("midreset_idle", 64'(bus.busy), 64'd0);

    // Long fault-free run, long enough for the counter to wrap.
    for (int i = 0; i < 300; i++) begin
      exec_one(4'($urandom_range(1, 11)), 1, 0, 1'($urandom_range(0, 1)),
               {$urandom, $urandom}, ($urandom_range(0, 3) == 0),
               $urandom_range(1, MEM_TIMEOUT), 0);
    end

    // Random mix including faults and halts.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      exec_one(4'($urandom_range(0, 15)), ($urandom_range(0, 9) != 0),
               ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
               {$urandom, $urandom}, ($urandom_range(0, 3) == 0),
               $urandom_range(0, MEM_TIMEOUT), ($urandom_range(0, 7) == 0));
      if (exp_stat != 3'd1) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
